msg_poly_add: RTL and testbench

//  Downstream consumer of the message decompressor. Captures the 256 decompressed message

---
 rtl/msg_poly_add_pkg.sv | 21 ++
 rtl/dual_ram.sv | 34 +++
 rtl/mod_q_add.sv | 70 +++++++
 rtl/msg_poly_add.sv | 200 ++++++++++++++++++++
 tb/tb_msg_poly_add.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/msg_poly_add_pkg.sv
// Shared Kyber constants and the single conditional-subtraction helper.
package msg_poly_add_pkg;

  localparam int KYBER_Q      = 3329;
  localparam int KYBER_N      = 256;
  localparam int KYBER_NPAIRS = 128;
  localparam int COEF_W       = 12;

  // One conditional subtraction of q; inputs must satisfy s < 2q for a canonical result.
  function automatic logic [COEF_W-1:0] mod_q_reduce(input logic [COEF_W:0] s,
                                                     input logic [COEF_W:0] q);
    logic [COEF_W:0] diff;
    diff = s - q;
    if (s >= q) begin
      return diff[COEF_W-1:0];
    end else begin
      return s[COEF_W-1:0];
    end
  endfunction

endpackage

// File: rtl/dual_ram.sv
// Simple two-port RAM: port 1 write-only, port 2 registered read with enable.
module dual_ram #(
  parameter int AW = 7,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          re2,
  input  logic [AW-1:0] addr2,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata2_q;

  // Port 1 write; storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we1) begin
      mem_q[addr1] <= wdata1;
    end
  end

  // Port 2 read; data holds when no read is requested so a stalled pipeline keeps its operand.
  always_ff @(posedge clk) begin
    if (re2) begin
      rdata2_q <= mem_q[addr2];
    end
  end

  assign rdata2 = rdata2_q;

endmodule

// File: rtl/mod_q_add.sv
// Registered two-lane (a+b) mod Q with valid/index sideband; forms the output stage.
module mod_q_add
  import msg_poly_add_pkg::*;
#(
  parameter int Q  = KYBER_Q,
  parameter int CW = 16,
  parameter int IW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  input  logic [IW-1:0]     in_index,
  input  logic [COEF_W-1:0] a1,
  input  logic [COEF_W-1:0] b1,
  input  logic [COEF_W-1:0] a2,
  input  logic [COEF_W-1:0] b2,
  output logic              out_valid,
  output logic [IW-1:0]     out_index,
  output logic [CW-1:0]     sum_1,
  output logic [CW-1:0]     sum_2
);

  localparam logic [COEF_W:0] Q_W = (COEF_W+1)'(Q);

  logic              valid_q, valid_d;
  logic [IW-1:0]     index_q, index_d;
  logic [CW-1:0]     sum_1_q, sum_1_d;
  logic [CW-1:0]     sum_2_q, sum_2_d;
  logic [COEF_W:0]   s1_s, s2_s;

  // Next-state of the output stage; everything holds while en is low.
  always_comb begin
    s1_s    = {1'b0, a1} + {1'b0, b1};
    s2_s    = {1'b0, a2} + {1'b0, b2};
    valid_d = valid_q;
    index_d = index_q;
    sum_1_d = sum_1_q;
    sum_2_d = sum_2_q;
    if (en) begin
      valid_d = in_valid;
      index_d = in_index;
      sum_1_d = {{(CW-COEF_W){1'b0}}, mod_q_reduce(s1_s, Q_W)};
      sum_2_d = {{(CW-COEF_W){1'b0}}, mod_q_reduce(s2_s, Q_W)};
    end else begin
      valid_d = valid_q;
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      index_q <= '0;
      sum_1_q <= '0;
      sum_2_q <= '0;
    end else begin
      valid_q <= valid_d;
      index_q <= index_d;
      sum_1_q <= sum_1_d;
      sum_2_q <= sum_2_d;
    end
  end

  assign out_valid = valid_q;
  assign out_index = index_q;
  assign sum_1     = sum_1_q;
  assign sum_2     = sum_2_q;

endmodule

// File: rtl/msg_poly_add.sv
// Captures 128 decompressed message pairs, then adds them mod Q to a streamed operand.
module msg_poly_add
  import msg_poly_add_pkg::*;
#(
  parameter int Q      = KYBER_Q,
  parameter int CW     = 16,
  parameter int IW     = 8,
  parameter int NPAIRS = KYBER_NPAIRS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set,
  input  logic          readin,
  input  logic          full_in,
  input  logic [IW-1:0] in_index,
  input  logic [CW-1:0] msg_din_1,
  input  logic [CW-1:0] msg_din_2,
  input  logic          add_valid,
  input  logic [CW-1:0] add_din_1,
  input  logic [CW-1:0] add_din_2,
  output logic          readin_ok,
  output logic          add_ready,
  output logic [CW-1:0] dout_1,
  output logic [CW-1:0] dout_2,
  output logic [IW-1:0] out_index,
  output logic          out_valid,
  output logic          done
);

  localparam int            AW       = $clog2(NPAIRS);
  localparam int            DW       = 2 * COEF_W;
  localparam logic [IW-1:0] LAST_PC  = IW'(NPAIRS - 1);
  localparam logic [IW-1:0] NPAIRS_W = IW'(NPAIRS);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ADD, ST_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     pc_q, pc_d;
  logic              readin_ok_q, readin_ok_d;
  logic              add_ready_q, add_ready_d;
  logic              done_q, done_d;
  logic              s1_valid_q, s1_valid_d;
  logic [IW-1:0]     s1_index_q, s1_index_d;
  logic [COEF_W-1:0] s1_a1_q, s1_a1_d;
  logic [COEF_W-1:0] s1_a2_q, s1_a2_d;

  logic              ld_we_s, wb_we_s, accept_s, ram_we_s;
  logic [AW-1:0]     ram_waddr_s;
  logic [DW-1:0]     ram_wdata_s, ram_rdata_s;
  logic              unused_hi_s;

  // Operand/message bits above the 12-bit coefficient field carry no information.
  assign unused_hi_s = ^{msg_din_1[CW-1:COEF_W], msg_din_2[CW-1:COEF_W],
                         add_din_1[CW-1:COEF_W], add_din_2[CW-1:COEF_W]};

  // Handshakes and RAM port-1 muxing; the S1 zero write-back and LOAD writes never overlap.
  always_comb begin
    ld_we_s     = set & readin & readin_ok_q & (in_index < NPAIRS_W);
    accept_s    = set & add_valid & add_ready_q;
    wb_we_s     = set & s1_valid_q;
    ram_we_s    = ld_we_s | wb_we_s;
    if (wb_we_s) begin
      ram_waddr_s = s1_index_q[AW-1:0];
      ram_wdata_s = '0;
    end else begin
      ram_waddr_s = in_index[AW-1:0];
      ram_wdata_s = {msg_din_2[COEF_W-1:0], msg_din_1[COEF_W-1:0]};
    end
  end

  // FSM next-state, pair counter and handshake outputs; set=0 freezes everything.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    readin_ok_d = readin_ok_q;
    add_ready_d = add_ready_q;
    done_d      = done_q;
    if (set) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_LOAD;
          pc_d        = '0;
          readin_ok_d = 1'b0;
          add_ready_d = 1'b0;
        end
        ST_LOAD: begin
          if (full_in) begin
            state_d     = ST_ADD;
            readin_ok_d = 1'b0;
            add_ready_d = 1'b1;
            pc_d        = '0;
          end else begin
            readin_ok_d = 1'b1;
          end
        end
        ST_ADD: begin
          if (accept_s) begin
            pc_d = pc_q + IW'(1);
            if (pc_q == LAST_PC) begin
              add_ready_d = 1'b0;
              state_d     = ST_DRAIN;
            end else begin
              add_ready_d = 1'b1;
            end
          end else begin
            pc_d = pc_q;
          end
        end
        ST_DRAIN: begin
          // S1 empty means the last pair is being presented in S2 now.
          if (!s1_valid_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            pc_d    = '0;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      done_d = done_q;
    end
  end

  // S1 sideband: operand and index registered alongside the RAM read.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_index_d = s1_index_q;
    s1_a1_d    = s1_a1_q;
    s1_a2_d    = s1_a2_q;
    if (set) begin
      s1_valid_d = accept_s;
      s1_index_d = pc_q;
      s1_a1_d    = add_din_1[COEF_W-1:0];
      s1_a2_d    = add_din_2[COEF_W-1:0];
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Control and S1 registers with synchronous reset (reset wins over set).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      readin_ok_q <= 1'b0;
      add_ready_q <= 1'b0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_index_q  <= '0;
      s1_a1_q     <= '0;
      s1_a2_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      readin_ok_q <= readin_ok_d;
      add_ready_q <= add_ready_d;
      done_q      <= done_d;
      s1_valid_q  <= s1_valid_d;
      s1_index_q  <= s1_index_d;
      s1_a1_q     <= s1_a1_d;
      s1_a2_q     <= s1_a2_d;
    end
  end

  dual_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk    (clk),
    .we1    (ram_we_s),
    .addr1  (ram_waddr_s),
    .wdata1 (ram_wdata_s),
    .re2    (accept_s),
    .addr2  (pc_q[AW-1:0]),
    .rdata2 (ram_rdata_s)
  );

  mod_q_add #(.Q(Q), .CW(CW), .IW(IW)) u_add (
    .clk       (clk),
    .reset     (reset),
    .en        (set),
    .in_valid  (s1_valid_q),
    .in_index  (s1_index_q),
    .a1        (ram_rdata_s[COEF_W-1:0]),
    .b1        (s1_a1_q),
    .a2        (ram_rdata_s[DW-1:COEF_W]),
    .b2        (s1_a2_q),
    .out_valid (out_valid),
    .out_index (out_index),
    .sum_1     (dout_1),
    .sum_2     (dout_2)
  );

  assign readin_ok = readin_ok_q;
  assign add_ready = add_ready_q;
  assign done      = done_q;

endmodule

// File: tb/tb_msg_poly_add.sv
// Directed bench for msg_poly_add: load/add passes with hand-computed expectations.
module tb_msg_poly_add;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set = 1'b1;
  logic        readin = 1'b0;
  logic        full_in = 1'b0;
  logic [7:0]  in_index = 8'd0;
  logic [15:0] msg_din_1 = 16'd0;
  logic [15:0] msg_din_2 = 16'd0;
  logic        add_valid = 1'b0;
  logic [15:0] add_din_1 = 16'd0;
  logic [15:0] add_din_2 = 16'd0;
  logic        readin_ok, add_ready, out_valid, done;
  logic [15:0] dout_1, dout_2;
  logic [7:0]  out_index;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_n, out_cnt, done_cnt, ord_err, last_out_cyc, done_cyc;
  int acc_cyc [128];
  int lat [128];
  logic [15:0] res1 [128];
  logic [15:0] res2 [128];
  logic [7:0]  next_idx;

  always #5 clk = ~clk;

  msg_poly_add dut (
    .clk(clk), .reset(reset), .set(set), .readin(readin), .full_in(full_in),
    .in_index(in_index), .msg_din_1(msg_din_1), .msg_din_2(msg_din_2),
    .add_valid(add_valid), .add_din_1(add_din_1), .add_din_2(add_din_2),
    .readin_ok(readin_ok), .add_ready(add_ready), .dout_1(dout_1), .dout_2(dout_2),
    .out_index(out_index), .out_valid(out_valid), .done(done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: note accept before the edge, then record outputs produced by that edge.
  task automatic tick();
    logic acc_now, set_b;
    acc_now = add_valid & add_ready & set & ~reset;
    set_b   = set & ~reset;
    @(posedge clk);
    #1;
    cyc++;
    if (acc_now) begin
      if (acc_n < 128) acc_cyc[acc_n] = cyc - 1;
      acc_n++;
    end
    if (out_valid && set_b) begin
      out_cnt++;
      last_out_cyc = cyc;
      if (out_index != next_idx) ord_err++;
      next_idx++;
      if (out_index < 8'd128) begin
        res1[out_index] = dout_1;
        res2[out_index] = dout_2;
        lat[out_index]  = cyc - acc_cyc[out_index];
      end
    end
    if (done && set_b) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic clear_mon();
    acc_n = 0; out_cnt = 0; done_cnt = 0; ord_err = 0; next_idx = 8'd0;
    last_out_cyc = 0; done_cyc = 0;
    for (int i = 0; i < 128; i++) begin
      res1[i] = 16'hFFFF; res2[i] = 16'hFFFF; lat[i] = 0; acc_cyc[i] = 0;
    end
  endtask

  task automatic wait_load(input string tag);
    int k;
    k = 0;
    while (!readin_ok && k < 10) begin
      tick();
      k++;
    end
    check_eq({tag, "_readin_ok"}, 64'(readin_ok), 64'd1);
  endtask

  task automatic load_pair(input int idx, input int m1, input int m2, input bit last, input int gap);
    readin = 1'b1; full_in = last; in_index = 8'(idx);
    msg_din_1 = 16'(m1); msg_din_2 = 16'(m2);
    tick();
    readin = 1'b0; full_in = 1'b0;
    repeat (gap) tick();
  endtask

  // mode 0: constant operand, 1: add_valid toggling, 2: index-dependent operand,
  // 3: constant operand with garbage in bits above 11.
  task automatic run_add(input string tag, input int mode, input int a1, input int a2,
                         input int limit, input int pause_at);
    int k, guard;
    bit paused;
    logic [63:0] snap;
    k = 0; guard = 0; paused = 1'b0;
    while (!add_ready && guard < 10) begin
      tick();
      guard++;
    end
    check_eq({tag, "_add_ready"}, 64'(add_ready), 64'd1);
    guard = 0;
    while (acc_n < limit && guard < 1000) begin
      if (acc_n == pause_at && !paused) begin
        paused = 1'b1;
        snap = {22'd0, out_valid, add_ready, out_index, dout_1, dout_2};
        set = 1'b0; add_valid = 1'b1; add_din_1 = 16'd123; add_din_2 = 16'd456;
        repeat (5) tick();
        check_eq({tag, "_frozen"}, {22'd0, out_valid, add_ready, out_index, dout_1, dout_2}, snap);
        set = 1'b1;
      end
      add_valid = (mode == 1) ? (k % 2 == 0) : 1'b1;
      case (mode)
        2: begin add_din_1 = 16'(acc_n * 26); add_din_2 = 16'(3328 - acc_n); end
        3: begin add_din_1 = 16'(a1) | 16'hF000; add_din_2 = 16'(a2) | 16'hA000; end
        default: begin add_din_1 = 16'(a1); add_din_2 = 16'(a2); end
      endcase
      tick();
      k++;
      guard++;
    end
    check_eq({tag, "_accepts"}, 64'(acc_n), 64'(limit));
    add_valid = 1'b0;
  endtask

  task automatic finish_add(input string tag);
    int g;
    g = 0;
    while (done_cnt == 0 && g < 10) begin
      tick();
      g++;
    end
    repeat (3) tick();
    check_eq({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check_eq({tag, "_done_gap"}, 64'(done_cyc - last_out_cyc), 64'd1);
    check_eq({tag, "_out_cnt"}, 64'(out_cnt), 64'd128);
    check_eq({tag, "_order"}, 64'(ord_err), 64'd0);
  endtask

  int bad, e1, e2;

  initial begin
    // Reset state
    clear_mon();
    tick(); tick();
    check_eq("rst_outs", {out_valid, done, readin_ok, add_ready, dout_1, dout_2, out_index},
             64'd0);
    reset = 1'b0;

    // Test 1: msg (1665,0) + operand (0,1664)
    wait_load("t1");
    for (int i = 0; i < 128; i++) load_pair(i, 1665, 0, i == 127, 0);
    run_add("t1", 0, 0, 1664, 128, 999);
    finish_add("t1");
    bad = 0;
    for (int i = 0; i < 128; i++) if (res1[i] !== 16'd1665 || res2[i] !== 16'd1664) bad++;
    check_eq("t1_vals", 64'(bad), 64'd0);
    check_eq("t1_p127", {res1[127], res2[127]}, {16'd1665, 16'd1664});

    // Test 2: msg (1665,1665) + operand (1664,1665), garbage high bits
    clear_mon();
    wait_load("t2");
    for (int i = 0; i < 128; i++) load_pair(i, 32'hF000 + 1665, 32'hC000 + 1665, i == 127, 0);
    run_add("t2", 3, 1664, 1665, 128, 999);
    finish_add("t2");
    bad = 0;
    for (int i = 0; i < 128; i++) if (res1[i] !== 16'd0 || res2[i] !== 16'd1) bad++;
    check_eq("t2_vals", 64'(bad), 64'd0);
    check_eq("t2_p0", {res1[0], res2[0]}, {16'd0, 16'd1});

    // Test 3: reverse-order load with 10 idle cycles, operand (100,3000)
    clear_mon();
    wait_load("t3");
    for (int i = 127; i >= 0; i--)
      load_pair(i, (i % 2) ? 1665 : 0, (i % 3 == 0) ? 1665 : 0, i == 0, 10);
    run_add("t3", 0, 100, 3000, 128, 999);
    finish_add("t3");
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      e1 = (i % 2) ? 1765 : 100;
      e2 = (i % 3 == 0) ? 1336 : 3000;
      if (res1[i] !== 16'(e1) || res2[i] !== 16'(e2)) bad++;
    end
    check_eq("t3_vals", 64'(bad), 64'd0);
    check_eq("t3_p3", {res1[3], res2[3]}, {16'd1765, 16'd1336});

    // Test 4: add_valid toggling, latency exactly 2
    clear_mon();
    wait_load("t4");
    for (int i = 0; i < 128; i++) load_pair(i, 0, 1665, i == 127, 0);
    run_add("t4", 1, 3328, 1664, 128, 999);
    check_eq("t4_ready_low", 64'(add_ready), 64'd0);
    finish_add("t4");
    bad = 0;
    for (int i = 0; i < 128; i++) if (lat[i] != 2) bad++;
    check_eq("t4_latency", 64'(bad), 64'd0);
    bad = 0;
    for (int i = 0; i < 128; i++) if (res1[i] !== 16'd3328 || res2[i] !== 16'd0) bad++;
    check_eq("t4_vals", 64'(bad), 64'd0);

    // Test 5: reset after 50 accepts
    clear_mon();
    wait_load("t5");
    for (int i = 0; i < 128; i++) load_pair(i, 1665, 0, i == 127, 0);
    run_add("t5", 0, 0, 0, 50, 999);
    reset = 1'b1;
    tick();
    check_eq("t5_rst_outs", {out_valid, done, readin_ok, add_ready, dout_1, dout_2, out_index},
             64'd0);
    reset = 1'b0;
    tick();
    check_eq("t5_ok_early", 64'(readin_ok), 64'd0);
    tick();
    check_eq("t5_ok_late", 64'(readin_ok), 64'd1);
    repeat (4) tick();
    check_eq("t5_no_done", 64'(done_cnt), 64'd0);

    // Test 7: set=0 for 5 cycles mid-ADD, varying operand
    clear_mon();
    wait_load("t7");
    for (int i = 0; i < 128; i++) load_pair(i, 1665, 1665, i == 127, 0);
    run_add("t7", 2, 0, 0, 128, 40);
    finish_add("t7");
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      e1 = (1665 + i * 26) % 3329;
      e2 = 1664 - i;
      if (res1[i] !== 16'(e1) || res2[i] !== 16'(e2)) bad++;
    end
    check_eq("t7_vals", 64'(bad), 64'd0);
    check_eq("t7_p40", {res1[40], res2[40]}, {16'd2705, 16'd1624});

    // Test 6: only index 5 loaded after a complete pass; operand (7,7)
    clear_mon();
    wait_load("t6");
    load_pair(5, 1665, 1665, 1'b1, 0);
    run_add("t6", 0, 7, 7, 128, 999);
    finish_add("t6");
    check_eq("t6_p5", {res1[5], res2[5]}, {16'd1672, 16'd1672});
    bad = 0;
    for (int i = 0; i < 128; i++) if (i != 5 && (res1[i] !== 16'd7 || res2[i] !== 16'd7)) bad++;
    check_eq("t6_others", 64'(bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
